axi_4_slave_controller: RTL and testbench

Slave-side (memory-side) handshake controller. It consumes the valid/ready/last signals driven by the AXI4 master controller and produces the matching slave handshakes (s_arready, s_rvalid, s_rlast, s_awready, s_wready, s_bvalid). It also sequences a single-port memory through per-beat read requests and write enables. One transaction is in flight at a time: one read burst or one write burst.

---
 rtl/axi_4_slave_controller_pkg.sv | 16 +
 rtl/axi_4_slave_controller_if.sv | 44 ++++
 rtl/axi_4_slave_controller.sv | 143 ++++++++++++++
 tb/tb_axi_4_slave_controller.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_4_slave_controller_pkg.sv
// rtl/axi_4_slave_controller_pkg.sv - shared states and response codes for the slave handshake controller
package axi_4_slave_controller_pkg;

    typedef enum logic [2:0] {
        SLAVE_IDLE,
        RD_REQ,
        RD_WAIT,
        RD_RESP,
        WR_DATA,
        WR_RESP
    } axi_4_slave_states_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_4_slave_controller_if.sv
// rtl/axi_4_slave_controller_if.sv - master/memory handshake bundle seen by the slave controller
interface axi_4_slave_controller_if #(
    parameter int LEN_W = 8
);
    logic             m_arvalid;
    logic [LEN_W-1:0] m_arlen;
    logic             m_rready;
    logic             m_awvalid;
    logic [LEN_W-1:0] m_awlen;
    logic             m_wvalid;
    logic             m_wlast;
    logic             m_bready;
    logic             mem_rd_valid;
    logic             mem_wr_ready;

    logic             s_arready;
    logic             s_rvalid;
    logic             s_rlast;
    logic             s_awready;
    logic             s_wready;
    logic             s_bvalid;
    logic [1:0]       s_bresp;
    logic             mem_rd_req;
    logic             rd_capture;
    logic             mem_wr_en;
    logic             latch_raddr;
    logic             latch_waddr;
    logic [LEN_W-1:0] beat_cnt;

    modport slave (
        input  m_arvalid, m_arlen, m_rready, m_awvalid, m_awlen,
               m_wvalid, m_wlast, m_bready, mem_rd_valid, mem_wr_ready,
        output s_arready, s_rvalid, s_rlast, s_awready, s_wready, s_bvalid, s_bresp,
               mem_rd_req, rd_capture, mem_wr_en, latch_raddr, latch_waddr, beat_cnt
    );

    modport master (
        output m_arvalid, m_arlen, m_rready, m_awvalid, m_awlen,
               m_wvalid, m_wlast, m_bready, mem_rd_valid, mem_wr_ready,
        input  s_arready, s_rvalid, s_rlast, s_awready, s_wready, s_bvalid, s_bresp,
               mem_rd_req, rd_capture, mem_wr_en, latch_raddr, latch_waddr, beat_cnt
    );

endinterface

// File: rtl/axi_4_slave_controller.sv
// rtl/axi_4_slave_controller.sv - memory-side AXI4 handshake controller, one read or write burst in flight
module axi_4_slave_controller
    import axi_4_slave_controller_pkg::*;
#(
    parameter int LEN_W      = 8,
    parameter bit STRICT_LEN = 1'b1
) (
    input  logic clk,
    input  logic reset,
    axi_4_slave_controller_if.slave bus
);

    axi_4_slave_states_e state_q, state_d;
    logic [LEN_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic                err_q, err_d;
    logic                rvalid_q, rvalid_d;
    logic                bvalid_q, bvalid_d;
    logic                w_hs;
    logic                at_len;

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        len_d      = len_q;
        err_d      = err_q;
        rvalid_d   = rvalid_q;
        bvalid_d   = bvalid_q;
        w_hs       = 1'b0;
        at_len     = (beat_cnt_q == len_q);

        bus.s_arready   = 1'b0;
        bus.s_awready   = 1'b0;
        bus.s_wready    = 1'b0;
        bus.mem_rd_req  = 1'b0;
        bus.rd_capture  = 1'b0;
        bus.mem_wr_en   = 1'b0;
        bus.latch_raddr = 1'b0;
        bus.latch_waddr = 1'b0;

        case (state_q)
            SLAVE_IDLE: begin
                bus.s_arready = 1'b1;
                bus.s_awready = !bus.m_arvalid;
                bus.s_wready  = bus.m_awvalid && !bus.m_arvalid && bus.mem_wr_ready;
                if (bus.m_arvalid) begin
                    bus.latch_raddr = 1'b1;
                    len_d           = bus.m_arlen;
                    beat_cnt_d      = '0;
                    state_d         = RD_REQ;
                end else if (bus.m_awvalid) begin
                    bus.latch_waddr = 1'b1;
                    len_d           = bus.m_awlen;
                    beat_cnt_d      = '0;
                    state_d         = WR_DATA;
                    // First beat may ride along with its address; it is beat 0 of the new burst.
                    w_hs   = bus.m_wvalid && bus.mem_wr_ready;
                    at_len = (bus.m_awlen == '0);
                    if (w_hs) begin
                        bus.mem_wr_en = 1'b1;
                        beat_cnt_d    = LEN_W'(1);
                        if (bus.m_wlast || at_len) begin
                            err_d    = STRICT_LEN && (bus.m_wlast != at_len);
                            bvalid_d = 1'b1;
                            state_d  = WR_RESP;
                        end
                    end
                end
            end
            RD_REQ: begin
                bus.mem_rd_req = 1'b1;
                state_d        = RD_WAIT;
            end
            RD_WAIT: begin
                bus.rd_capture = bus.mem_rd_valid;
                if (bus.mem_rd_valid) begin
                    rvalid_d = 1'b1;
                    state_d  = RD_RESP;
                end
            end
            RD_RESP: begin
                if (bus.m_rready) begin
                    rvalid_d = 1'b0;
                    if (at_len) begin
                        beat_cnt_d = '0;
                        state_d    = SLAVE_IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                        state_d    = RD_REQ;
                    end
                end
            end
            WR_DATA: begin
                bus.s_wready = bus.mem_wr_ready;
                w_hs         = bus.m_wvalid && bus.mem_wr_ready;
                if (w_hs) begin
                    bus.mem_wr_en = 1'b1;
                    beat_cnt_d    = beat_cnt_q + 1'b1;
                    // Either side may end the burst; disagreement is only flagged in strict mode.
                    if (bus.m_wlast || at_len) begin
                        err_d    = STRICT_LEN && (bus.m_wlast != at_len);
                        bvalid_d = 1'b1;
                        state_d  = WR_RESP;
                    end
                end
            end
            WR_RESP: begin
                if (bus.m_bready) begin
                    bvalid_d   = 1'b0;
                    err_d      = 1'b0;
                    beat_cnt_d = '0;
                    state_d    = SLAVE_IDLE;
                end
            end
            default: state_d = SLAVE_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= SLAVE_IDLE;
            beat_cnt_q <= '0;
            len_q      <= '0;
            err_q      <= 1'b0;
            rvalid_q   <= 1'b0;
            bvalid_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            len_q      <= len_d;
            err_q      <= err_d;
            rvalid_q   <= rvalid_d;
            bvalid_q   <= bvalid_d;
        end
    end

    assign bus.s_rvalid = rvalid_q;
    assign bus.s_rlast  = rvalid_q && (beat_cnt_q == len_q);
    assign bus.s_bvalid = bvalid_q;
    assign bus.s_bresp  = (bvalid_q && err_q) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    assign bus.beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_axi_4_slave_controller.sv
// tb/tb_axi_4_slave_controller.sv - bench for the slave handshake controller, strict and lax instances
module tb_axi_4_slave_controller;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic       m_arvalid = 0, m_rready = 0, m_awvalid = 0, m_wvalid = 0, m_wlast = 0, m_bready = 0;
    logic [7:0] m_arlen = 0, m_awlen = 0;
    logic       mem_rd_valid = 0, mem_wr_ready = 0;

    axi_4_slave_controller_if #(.LEN_W(8)) ifa ();
    axi_4_slave_controller_if #(.LEN_W(8)) ifb ();

    assign ifa.m_arvalid = m_arvalid;       assign ifb.m_arvalid = m_arvalid;
    assign ifa.m_arlen = m_arlen;           assign ifb.m_arlen = m_arlen;
    assign ifa.m_rready = m_rready;         assign ifb.m_rready = m_rready;
    assign ifa.m_awvalid = m_awvalid;       assign ifb.m_awvalid = m_awvalid;
    assign ifa.m_awlen = m_awlen;           assign ifb.m_awlen = m_awlen;
    assign ifa.m_wvalid = m_wvalid;         assign ifb.m_wvalid = m_wvalid;
    assign ifa.m_wlast = m_wlast;           assign ifb.m_wlast = m_wlast;
    assign ifa.m_bready = m_bready;         assign ifb.m_bready = m_bready;
    assign ifa.mem_rd_valid = mem_rd_valid; assign ifb.mem_rd_valid = mem_rd_valid;
    assign ifa.mem_wr_ready = mem_wr_ready; assign ifb.mem_wr_ready = mem_wr_ready;

    axi_4_slave_controller #(.LEN_W(8), .STRICT_LEN(1'b1)) dut (.clk(clk), .reset(reset), .bus(ifa));
    axi_4_slave_controller #(.LEN_W(8), .STRICT_LEN(1'b0)) dut_lax (.clk(clk), .reset(reset), .bus(ifb));

    // {arready,rvalid,rlast,awready,wready,bvalid,bresp[1:0],rd_req,capture,wr_en,lraddr,lwaddr,beat[7:0]}
    logic [20:0] act_a, act_b;
    assign act_a = {ifa.s_arready, ifa.s_rvalid, ifa.s_rlast, ifa.s_awready, ifa.s_wready, ifa.s_bvalid,
                    ifa.s_bresp, ifa.mem_rd_req, ifa.rd_capture, ifa.mem_wr_en, ifa.latch_raddr,
                    ifa.latch_waddr, ifa.beat_cnt};
    assign act_b = {ifb.s_arready, ifb.s_rvalid, ifb.s_rlast, ifb.s_awready, ifb.s_wready, ifb.s_bvalid,
                    ifb.s_bresp, ifb.mem_rd_req, ifb.rd_capture, ifb.mem_wr_en, ifb.latch_raddr,
                    ifb.latch_waddr, ifb.beat_cnt};

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [20:0] mk(input logic ar, rv, rl, aw, wr, bv, input logic [1:0] br,
                                       input logic rq, rc, we, lr, lw, input logic [7:0] bc);
        return {ar, rv, rl, aw, wr, bv, br, rq, rc, we, lr, lw, bc};
    endfunction

    // ---------------- reference model: walks each burst as a transaction ----------------
    bit abort;

    task automatic nc();
        @(negedge clk);
        abort = !reset;
    endtask

    task automatic cmp(input logic [20:0] e);
        chk("strict_outputs", {11'd0, act_a}, {11'd0, e});
        chk("lax_outputs", {11'd0, act_b}, {11'd0, e & ~21'h006000});
    endtask

    task automatic idle_cmp();
        logic aw_ok, w_ok;
        aw_ok = m_awvalid && !m_arvalid;
        w_ok  = aw_ok && m_wvalid && mem_wr_ready;
        cmp(mk(1'b1, 1'b0, 1'b0, !m_arvalid, aw_ok && mem_wr_ready, 1'b0, 2'b00,
               1'b0, 1'b0, w_ok, m_arvalid, aw_ok, 8'd0));
    endtask

    task automatic run_read(input int len);
        bit got, taken;
        for (int b = 0; b <= len; b++) begin
            nc();
            if (abort) begin idle_cmp(); return; end
            cmp(mk(0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 8'(b)));
            got = 0;
            while (!got) begin
                nc();
                if (abort) begin idle_cmp(); return; end
                got = mem_rd_valid;
                cmp(mk(0, 0, 0, 0, 0, 0, 2'b00, 0, got, 0, 0, 0, 8'(b)));
            end
            taken = 0;
            while (!taken) begin
                nc();
                if (abort) begin idle_cmp(); return; end
                taken = m_rready;
                cmp(mk(0, 1, b == len, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 8'(b)));
            end
        end
    endtask

    task automatic run_write(input int len, input bit first_beat, input bit first_last);
        int cnt;
        bit last, err, hs, taken;
        cnt = 0; last = 0; err = 0;
        if (first_beat) begin
            cnt  = 1;
            last = first_last || (len == 0);
            err  = first_last != (len == 0);
        end
        while (!last) begin
            nc();
            if (abort) begin idle_cmp(); return; end
            hs = m_wvalid && mem_wr_ready;
            cmp(mk(0, 0, 0, 0, mem_wr_ready, 0, 2'b00, 0, 0, hs, 0, 0, 8'(cnt)));
            if (hs) begin
                last = m_wlast || (cnt == len);
                err  = m_wlast != (cnt == len);
                cnt++;
            end
        end
        taken = 0;
        while (!taken) begin
            nc();
            if (abort) begin idle_cmp(); return; end
            taken = m_bready;
            cmp(mk(0, 0, 0, 0, 0, 1, err ? 2'b10 : 2'b00, 0, 0, 0, 0, 0, 8'(cnt)));
        end
    endtask

    initial begin : model
        forever begin
            nc();
            idle_cmp();
            if (!abort) begin
                if (m_arvalid) run_read(int'(m_arlen));
                else if (m_awvalid) run_write(int'(m_awlen), m_wvalid && mem_wr_ready, m_wlast);
            end
        end
    end

    // ---------------- event counters for literal expectations ----------------
    int cyc = 0, n_req = 0, n_rlast = 0, n_wen = 0, n_lw = 0;
    int ar_cyc = 0, lw_cyc = 0, rhs_cyc = 0;
    int rv_q[$];
    bit rv_prev = 0;

    initial begin : monitor
        forever begin
            @(negedge clk);
            cyc++;
            if (ifa.mem_rd_req) n_req++;
            if (ifa.s_rvalid && ifa.s_rlast && m_rready) n_rlast++;
            if (ifa.mem_wr_en) n_wen++;
            if (ifa.latch_raddr) ar_cyc = cyc;
            if (ifa.latch_waddr) begin n_lw++; lw_cyc = cyc; end
            if (ifa.s_rvalid && m_rready) rhs_cyc = cyc;
            if (ifa.s_rvalid && !rv_prev) rv_q.push_back(cyc);
            rv_prev = ifa.s_rvalid;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rv(input logic [7:0] b, input string nm);
        int k;
        k = 0;
        while (!(ifa.s_rvalid && ifa.beat_cnt == b) && k < 40) begin tick(); k++; end
        chk(nm, 32'(k < 40), 32'd1);
    endtask

    task automatic quiet();
        m_arvalid = 0; m_awvalid = 0; m_wvalid = 0; m_wlast = 0;
        m_rready = 0; m_bready = 0; mem_rd_valid = 0; mem_wr_ready = 0;
    endtask

    initial begin : driver
        int s_req, s_rlast, s_wen, s_lw, s_rv, k;
        bit seen_b;
        logic [1:0] resp;

        repeat (3) tick();
        chk("rst_rvalid", ifa.s_rvalid, 0);
        chk("rst_bvalid", ifa.s_bvalid, 0);
        chk("rst_bresp", ifa.s_bresp, 0);
        chk("rst_beat", ifa.beat_cnt, 0);
        reset = 1;
        tick();

        // 1: four-beat read, zero-wait memory
        s_req = n_req; s_rlast = n_rlast; s_rv = rv_q.size();
        mem_rd_valid = 1; m_rready = 1; m_arvalid = 1; m_arlen = 3;
        tick(); m_arvalid = 0;
        repeat (14) tick();
        chk("t1_rd_req_pulses", n_req - s_req, 4);
        chk("t1_rlast_count", n_rlast - s_rlast, 1);
        chk("t1_rvalid_pulses", rv_q.size() - s_rv, 4);
        if (rv_q.size() - s_rv == 4) begin
            chk("t1_first_latency", rv_q[s_rv] - ar_cyc, 3);
            chk("t1_beat_spacing", rv_q[s_rv + 3] - rv_q[s_rv], 9);
        end
        quiet(); tick();

        // 2: master back-pressure on beat 1
        s_req = n_req;
        mem_rd_valid = 1; m_arvalid = 1; m_arlen = 1;
        tick(); m_arvalid = 0;
        wait_rv(8'd0, "t2_beat0_timeout");
        m_rready = 1; tick(); m_rready = 0;
        wait_rv(8'd1, "t2_beat1_timeout");
        repeat (5) tick();
        chk("t2_rvalid_held", ifa.s_rvalid, 1);
        chk("t2_beat_held", ifa.beat_cnt, 1);
        chk("t2_rd_req_total", n_req - s_req, 2);
        m_rready = 1; tick(); quiet(); tick();

        // 3: three-beat write with toggling memory readiness
        s_wen = n_wen; seen_b = 0; resp = 2'b11;
        m_bready = 1; m_wvalid = 1; mem_wr_ready = 1; m_awvalid = 1; m_awlen = 2;
        for (int i = 0; i < 20; i++) begin
            tick();
            m_awvalid = 0;
            mem_wr_ready = ~mem_wr_ready;
            m_wlast = (ifa.beat_cnt == 8'd2) && !ifa.s_bvalid;
            if (ifa.s_bvalid) begin seen_b = 1; resp = ifa.s_bresp; end
        end
        chk("t3_wr_en_count", n_wen - s_wen, 3);
        chk("t3_bvalid_seen", 32'(seen_b), 1);
        chk("t3_bresp", resp, 2'b00);
        quiet(); tick();

        // 4: simultaneous AR and AW, read wins
        s_wen = n_wen; s_lw = n_lw;
        m_arvalid = 1; m_arlen = 0; m_awvalid = 1; m_awlen = 0; m_wvalid = 1; m_wlast = 1;
        mem_wr_ready = 1; mem_rd_valid = 1; m_rready = 1; m_bready = 1;
        #1;
        chk("t4_arready", ifa.s_arready, 1);
        chk("t4_awready", ifa.s_awready, 0);
        chk("t4_wready", ifa.s_wready, 0);
        tick(); m_arvalid = 0;
        k = 0;
        while (!ifa.latch_waddr && k < 20) begin tick(); k++; end
        chk("t4_aw_timeout", 32'(k < 20), 1);
        tick(); m_awvalid = 0;
        repeat (3) tick();
        chk("t4_aw_after_read", lw_cyc - rhs_cyc, 1);
        chk("t4_wr_en_count", n_wen - s_wen, 1);
        chk("t4_aw_count", n_lw - s_lw, 1);
        quiet(); tick();

        // 5: early WLAST on a four-beat burst
        s_wen = n_wen;
        m_wvalid = 1; mem_wr_ready = 1; m_awvalid = 1; m_awlen = 3;
        k = 0;
        while (!ifa.s_bvalid && k < 20) begin
            tick(); m_awvalid = 0; m_wlast = (ifa.beat_cnt == 8'd1); k++;
        end
        chk("t5_bvalid_timeout", 32'(k < 20), 1);
        chk("t5_bresp_strict", ifa.s_bresp, 2'b10);
        chk("t5_bresp_lax", ifb.s_bresp, 2'b00);
        chk("t5_wr_en_count", n_wen - s_wen, 2);
        chk("t5_beats", ifa.beat_cnt, 2);
        m_wvalid = 0; m_wlast = 0; m_bready = 1; tick(); quiet(); tick();

        // 6: reset mid-read (RD_WAIT) and mid-write (WR_DATA)
        m_arvalid = 1; m_arlen = 2;
        tick(); m_arvalid = 0;
        tick();
        #2 reset = 0;
        #1 chk("t6_rd_reset", {11'd0, act_a}, 32'h0012_0000);
        tick(); reset = 1; tick();
        m_awvalid = 1; m_awlen = 3;
        tick(); m_awvalid = 0; m_wvalid = 1; mem_wr_ready = 1;
        tick(); m_wvalid = 0;
        chk("t6_wr_progress", ifa.beat_cnt, 1);
        m_wvalid = 1;
        #2 reset = 0;
        #1 chk("t6_wr_reset", {11'd0, act_a}, 32'h0012_0000);
        tick(); quiet(); reset = 1; tick();

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            m_arvalid    = ($urandom_range(0, 3) == 0);
            m_arlen      = 8'($urandom_range(0, 3));
            m_awvalid    = ($urandom_range(0, 3) == 0);
            m_awlen      = 8'($urandom_range(0, 3));
            m_rready     = $urandom_range(0, 1) == 1;
            m_wvalid     = ($urandom_range(0, 9) < 7);
            m_wlast      = ($urandom_range(0, 9) < 3);
            m_bready     = $urandom_range(0, 1) == 1;
            mem_rd_valid = $urandom_range(0, 1) == 1;
            mem_wr_ready = ($urandom_range(0, 9) < 7);
            reset        = ($urandom_range(0, 599) != 0);
            tick();
        end
        reset = 1; quiet();
        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
